// File: rtl/pe_array_seq_if.sv
// Host-side bundle of the Life PE array sequencer: cell loads, run control,
// status and the readout stream. master = host, slave = sequencer.
`ifndef PE_CMD_BITS
`define PE_CMD_BITS    2
`define PE_CMD_NOP     2'd0
`define PE_CMD_WRITE   2'd1
`define PE_CMD_PROCESS 2'd2
`endif
`ifndef PE_STATE_BITS
`define PE_STATE_BITS  1
`endif

interface pe_array_seq_if #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int GEN_BITS   = 16,
    parameter int STATE_BITS = `PE_STATE_BITS
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                  load_valid;
    logic                  load_ready;
    logic [RW-1:0]         load_row;
    logic [CW-1:0]         load_col;
    logic [STATE_BITS-1:0] load_state;
    logic                  start;
    logic [GEN_BITS-1:0]   n_gens;
    logic                  read_start;
    logic                  busy;
    logic                  done;
    logic                  stable;
    logic [GEN_BITS-1:0]   gen_count;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [RW-1:0]         rd_row;
    logic [CW-1:0]         rd_col;
    logic [STATE_BITS-1:0] rd_state;
    logic                  rd_last;

    modport master (
        output load_valid, load_row, load_col, load_state, start, n_gens,
               read_start, rd_ready,
        input  load_ready, busy, done, stable, gen_count, rd_valid, rd_row,
               rd_col, rd_state, rd_last
    );

    modport slave (
        input  load_valid, load_row, load_col, load_state, start, n_gens,
               read_start, rd_ready,
        output load_ready, busy, done, stable, gen_count, rd_valid, rd_row,
               rd_col, rd_state, rd_last
    );
endinterface

// File: rtl/pe_array_seq.sv
// Sequencer for the Life PE array: host cell loads, N-generation runs (or until
// stable) and a row-major readout stream; sole driver of the array command bus.
module pe_array_seq #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int GEN_BITS   = 16,
    parameter int STATE_BITS = `PE_STATE_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    pe_array_seq_if.slave           host,
    output logic [`PE_CMD_BITS-1:0] cmd,
    output logic [ROWS-1:0]         rsel_i,
    output logic [COLS-1:0]         csel_i,
    output logic [ROWS-1:0]         rsel_o,
    output logic [COLS-1:0]         csel_o,
    output logic [STATE_BITS-1:0]   state_in,
    input  logic                    any_active,
    input  logic [STATE_BITS-1:0]   array_state
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, PROC, READ} state_t;

    state_t                state;
    logic [GEN_BITS-1:0]   n_lim;
    logic [GEN_BITS-1:0]   gen_count;
    logic                  stable_r;
    logic                  done_r;
    logic [RW-1:0]         cur_row;
    logic [CW-1:0]         cur_col;
    logic                  issued_all;
    logic                  rd_valid_r;
    logic                  rd_last_r;
    logic [RW-1:0]         rd_row_r;
    logic [CW-1:0]         rd_col_r;
    logic [STATE_BITS-1:0] rd_state_r;

    function automatic logic [ROWS-1:0] row_hot(input logic [RW-1:0] r);
        row_hot = '0;
        for (int i = 0; i < ROWS; i++)
            if (int'(r) == i) row_hot[i] = 1'b1;
    endfunction

    function automatic logic [COLS-1:0] col_hot(input logic [CW-1:0] c);
        col_hot = '0;
        for (int i = 0; i < COLS; i++)
            if (int'(c) == i) col_hot[i] = 1'b1;
    endfunction

    logic [GEN_BITS-1:0] gen_next;
    logic                addr_ok;
    logic                cur_last;
    assign gen_next = gen_count + GEN_BITS'(1);
    assign addr_ok  = (int'(host.load_row) < ROWS) && (int'(host.load_col) < COLS);
    assign cur_last = (cur_row == RW'(ROWS - 1)) && (cur_col == CW'(COLS - 1));

    // Ready is only truthful when the FSM can actually take the write this edge.
    assign host.load_ready = !rst && (state == IDLE) && host.load_valid;
    assign host.busy       = (state != IDLE);
    assign host.done       = done_r;
    assign host.stable     = stable_r;
    assign host.gen_count  = gen_count;
    assign host.rd_valid   = rd_valid_r;
    assign host.rd_row     = rd_row_r;
    assign host.rd_col     = rd_col_r;
    assign host.rd_state   = rd_state_r;
    assign host.rd_last    = rd_last_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd        <= `PE_CMD_NOP;
            rsel_i     <= '0;
            csel_i     <= '0;
            rsel_o     <= '0;
            csel_o     <= '0;
            state_in   <= '0;
            n_lim      <= '0;
            gen_count  <= '0;
            stable_r   <= 1'b0;
            done_r     <= 1'b0;
            cur_row    <= '0;
            cur_col    <= '0;
            issued_all <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            rd_row_r   <= '0;
            rd_col_r   <= '0;
            rd_state_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.load_valid) begin
                        state    <= WRITE;
                        cmd      <= `PE_CMD_WRITE;
                        rsel_i   <= addr_ok ? row_hot(host.load_row) : '0;
                        csel_i   <= addr_ok ? col_hot(host.load_col) : '0;
                        state_in <= host.load_state;
                    end else if (host.start) begin
                        state     <= PROC;
                        cmd       <= `PE_CMD_PROCESS;
                        gen_count <= '0;
                        stable_r  <= 1'b0;
                        n_lim     <= host.n_gens;
                    end else if (host.read_start) begin
                        state      <= READ;
                        cur_row    <= '0;
                        cur_col    <= '0;
                        issued_all <= 1'b0;
                        rsel_o     <= row_hot('0);
                        csel_o     <= col_hot('0);
                    end
                end
                WRITE: begin
                    state  <= IDLE;
                    cmd    <= `PE_CMD_NOP;
                    rsel_i <= '0;
                    csel_i <= '0;
                end
                PROC: begin
                    gen_count <= gen_next;
                    // Quiet generation, reached limit, or counter about to saturate.
                    if (!any_active || (n_lim != '0 && gen_next == n_lim) ||
                        gen_next == '1) begin
                        state    <= IDLE;
                        cmd      <= `PE_CMD_NOP;
                        stable_r <= !any_active;
                        done_r   <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_valid_r && host.rd_ready && rd_last_r) begin
                        state      <= IDLE;
                        rd_valid_r <= 1'b0;
                        rd_last_r  <= 1'b0;
                        rsel_o     <= '0;
                        csel_o     <= '0;
                        done_r     <= 1'b1;
                    end else if ((!rd_valid_r || host.rd_ready) && !issued_all) begin
                        // Selects already point at cur_*, so array_state is that cell.
                        rd_valid_r <= 1'b1;
                        rd_row_r   <= cur_row;
                        rd_col_r   <= cur_col;
                        rd_state_r <= array_state;
                        rd_last_r  <= cur_last;
                        if (cur_last) begin
                            issued_all <= 1'b1;
                        end else if (cur_col == CW'(COLS - 1)) begin
                            cur_col <= '0;
                            cur_row <= cur_row + RW'(1);
                            rsel_o  <= row_hot(cur_row + RW'(1));
                            csel_o  <= col_hot('0);
                        end else begin
                            cur_col <= cur_col + CW'(1);
                            csel_o  <= col_hot(cur_col + CW'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_array_seq.sv
// Bench for pe_array_seq: 8x8 instance driving a behavioural Life array, and a
// 6x5 GEN_BITS=4 instance with an always-active array for saturation/abort cases.
module tb_pe_array_seq;
    localparam logic [1:0] CMD_NOP     = 2'd0;
    localparam logic [1:0] CMD_WRITE   = 2'd1;
    localparam logic [1:0] CMD_PROCESS = 2'd2;

    logic clk;
    logic rst;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    pe_array_seq_if #(.ROWS(8), .COLS(8), .GEN_BITS(16), .STATE_BITS(1)) h0 ();
    pe_array_seq_if #(.ROWS(6), .COLS(5), .GEN_BITS(4),  .STATE_BITS(1)) h1 ();

    logic [1:0] cmd0, cmd1;
    logic [7:0] rsel_i0, csel_i0, rsel_o0, csel_o0;
    logic [5:0] rsel_i1, rsel_o1;
    logic [4:0] csel_i1, csel_o1;
    logic [0:0] state_in0, state_in1, array_state0;
    logic       any_active0;

    pe_array_seq #(.ROWS(8), .COLS(8), .GEN_BITS(16), .STATE_BITS(1)) u0 (
        .clk(clk), .rst(rst), .host(h0), .cmd(cmd0),
        .rsel_i(rsel_i0), .csel_i(csel_i0), .rsel_o(rsel_o0), .csel_o(csel_o0),
        .state_in(state_in0), .any_active(any_active0), .array_state(array_state0)
    );

    pe_array_seq #(.ROWS(6), .COLS(5), .GEN_BITS(4), .STATE_BITS(1)) u1 (
        .clk(clk), .rst(rst), .host(h1), .cmd(cmd1),
        .rsel_i(rsel_i1), .csel_i(csel_i1), .rsel_o(rsel_o1), .csel_o(csel_o1),
        .state_in(state_in1), .any_active(1'b1), .array_state(1'b0)
    );

    // Behavioural 8x8 Life array, non-wrapping edges, cell (r,c) at bit r*8+c.
    logic [63:0] grid, grid_nxt;

    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            cnt += int'(g[rr*8+cc]);
                    end
                end
                n[r*8+c] = g[r*8+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    always_comb begin
        grid_nxt     = life_step(grid);
        any_active0  = (cmd0 == CMD_PROCESS) && (grid_nxt != grid);
        array_state0 = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (rsel_o0[r] && csel_o0[c] && grid[r*8+c]) array_state0 = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grid <= '0;
        end else if (cmd0 == CMD_WRITE) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    if (rsel_i0[r] && csel_i0[c]) grid[r*8+c] <= state_in0[0];
        end else if (cmd0 == CMD_PROCESS) begin
            grid <= grid_nxt;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load0(input int r, input int c, input logic s);
        h0.load_valid = 1'b1;
        h0.load_row   = 3'(r);
        h0.load_col   = 3'(c);
        h0.load_state = s;
        tick();
        h0.load_valid = 1'b0;
        tick();
    endtask

    task automatic run0(input logic [15:0] n, output int proc, output logic seen);
        h0.n_gens = n;
        h0.start  = 1'b1;
        tick();
        h0.start = 1'b0;
        proc = 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (cmd0 == CMD_PROCESS) proc++;
            if (h0.done) seen = 1'b1;
            else tick();
        end
    endtask

    typedef struct {
        string       name;
        logic [63:0] cells;
        logic [15:0] n_gens;
        int          exp_gen;
        logic        exp_stable;
    } run_vec_t;

    run_vec_t tv[5];
    localparam logic [63:0] BLINKER = 64'h0000_0000_1C00_0000;

    initial begin
        int   proc, beats, done_cnt;
        logic seen, tog;
        logic [7:0] exp_beat;

        tv[0] = '{"block",   64'h0000_0000_0006_0600, 16'd5, 1, 1'b1};
        tv[1] = '{"blinker", BLINKER,                 16'd4, 4, 1'b0};
        tv[2] = '{"empty",   64'h0,                   16'd0, 1, 1'b1};
        tv[3] = '{"single",  64'h1,                   16'd0, 2, 1'b1};
        tv[4] = '{"blink_n1", BLINKER,                16'd1, 1, 1'b0};

        {h0.load_valid, h0.start, h0.read_start, h0.rd_ready} = '0;
        {h1.load_valid, h1.start, h1.read_start, h1.rd_ready} = '0;
        h0.load_row = '0; h0.load_col = '0; h0.load_state = '0; h0.n_gens = '0;
        h1.load_row = '0; h1.load_col = '0; h1.load_state = '0; h1.n_gens = '0;

        // Reset state
        do_reset();
        chk("rst_cmd", cmd0, CMD_NOP);
        chk("rst_sel", {rsel_i0, csel_i0, rsel_o0, csel_o0}, 0);
        chk("rst_status", {h0.busy, h0.done, h0.stable, h0.load_ready, state_in0}, 0);
        chk("rst_gen", h0.gen_count, 0);
        chk("rst_rd", {h0.rd_valid, h0.rd_last, h0.rd_row, h0.rd_col, h0.rd_state}, 0);

        // Back-to-back loads: one accept every second cycle
        h0.load_valid = 1'b1; h0.load_row = 3'd2; h0.load_col = 3'd5; h0.load_state = 1'b1;
        #1 chk("ld1_ready", h0.load_ready, 1);
        tick();
        h0.load_row = 3'd7; h0.load_col = 3'd7;
        #1 chk("ld1_wr_ready", h0.load_ready, 0);
        chk("ld1_wr", {cmd0, rsel_i0, csel_i0, state_in0, h0.busy}, {CMD_WRITE, 8'h04, 8'h20, 1'b1, 1'b1});
        tick();
        chk("ld2_ready", h0.load_ready, 1);
        chk("ld2_idle_cmd", cmd0, CMD_NOP);
        tick();
        h0.load_valid = 1'b0;
        chk("ld2_wr", {cmd0, rsel_i0, csel_i0}, {CMD_WRITE, 8'h80, 8'h80});
        tick();
        chk("ld2_after", {cmd0, rsel_i0, csel_i0, h0.busy}, {CMD_NOP, 16'h0, 1'b0});
        chk("ld_cells", grid, 64'h8000_0000_0020_0000);

        // Table of runs
        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int b = 0; b < 64; b++)
                if (tv[t].cells[b]) load0(b / 8, b % 8, 1'b1);
            run0(tv[t].n_gens, proc, seen);
            chk({tv[t].name, "_done"}, seen, 1);
            chk({tv[t].name, "_gen"}, h0.gen_count, tv[t].exp_gen);
            chk({tv[t].name, "_stable"}, h0.stable, tv[t].exp_stable);
            chk({tv[t].name, "_proc"}, proc, tv[t].exp_gen);
            tick();
            chk({tv[t].name, "_pulse"}, h0.done, 0);
        end

        // Blinker run then readout with rd_ready toggling 1,0,1,0...
        do_reset();
        load0(3, 2, 1'b1); load0(3, 3, 1'b1); load0(3, 4, 1'b1);
        run0(16'd4, proc, seen);
        chk("rb_run", {seen, h0.stable, h0.gen_count}, {1'b1, 1'b0, 16'd4});
        tick();
        h0.read_start = 1'b1;
        tick();
        h0.read_start = 1'b0;
        chk("rb_sel_lead", {rsel_o0, csel_o0, h0.rd_valid}, {8'h01, 8'h01, 1'b0});
        tog = 1'b1;
        beats = 0;
        for (int cyc = 0; cyc < 400 && beats < 64; cyc++) begin
            h0.rd_ready = tog;
            #1;
            if (h0.rd_valid && h0.rd_ready) begin
                exp_beat = {3'(beats / 8), 3'(beats % 8), BLINKER[beats], beats == 63};
                chk($sformatf("rd_beat%0d", beats),
                    {h0.rd_row, h0.rd_col, h0.rd_state, h0.rd_last}, exp_beat);
                beats++;
            end
            tog = ~tog;
            tick();
        end
        h0.rd_ready = 1'b0;
        chk("rd_count", beats, 64);
        chk("rd_end", {h0.done, h0.busy, h0.rd_valid, rsel_o0, csel_o0}, {1'b1, 1'b0, 1'b0, 16'h0});

        // Out-of-range row and top-corner row/col on the 6x5 instance
        do_reset();
        h1.load_valid = 1'b1; h1.load_row = 3'd6; h1.load_col = 3'd0; h1.load_state = 1'b1;
        #1 chk("oor_ready", h1.load_ready, 1);
        tick();
        h1.load_valid = 1'b0;
        chk("oor_wr", {cmd1, rsel_i1, csel_i1}, {CMD_WRITE, 6'h0, 5'h0});
        tick();
        h1.load_valid = 1'b1; h1.load_row = 3'd5; h1.load_col = 3'd4;
        tick();
        h1.load_valid = 1'b0;
        chk("top_wr", {cmd1, rsel_i1, csel_i1}, {CMD_WRITE, 6'h20, 5'h10});
        tick();

        // Oscillating array, n_gens=0: saturates at 15; host inputs ignored mid-run
        h1.n_gens = 4'd0;
        h1.start = 1'b1;
        tick();
        h1.start = 1'b0;
        proc = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (cmd1 == CMD_PROCESS) proc++;
            if (i == 3) begin
                h1.load_valid = 1'b1; h1.read_start = 1'b1;
                #1 chk("busy_ld_ready", h1.load_ready, 0);
            end else begin
                h1.load_valid = 1'b0; h1.read_start = 1'b0;
            end
            if (h1.done) seen = 1'b1;
            else tick();
        end
        chk("sat_done", seen, 1);
        chk("sat_gen", h1.gen_count, 15);
        chk("sat_stable", h1.stable, 0);
        chk("sat_proc", proc, 15);
        tick();
        chk("sat_idle", {h1.busy, cmd1, h1.rd_valid}, 0);

        // Reset in the middle of a run aborts without done
        h1.start = 1'b1;
        tick();
        h1.start = 1'b0;
        tick(); tick();
        chk("abort_running", {h1.busy, cmd1}, {1'b1, CMD_PROCESS});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", {h1.busy, cmd1, h1.done, h1.gen_count}, 0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (h1.done || h1.busy) done_cnt++;
            tick();
        end
        chk("abort_no_done", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
